// File: rtl/pixel_downscale_2x.sv
// pixel_downscale_2x
// Expands an RGB565 camera stream to RGB888, averages each non-overlapping
// 2x2 block into one pixel and queues the results in a small valid/ready FIFO.
module pixel_downscale_2x #(
    parameter int IN_WIDTH   = 640,
    parameter int IN_HEIGHT  = 480,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        i_pclk,
    input  logic        i_reset,
    input  logic        i_frameStart,
    input  logic [15:0] i_pixel,
    input  logic        i_pixelValid,
    input  logic [9:0]  i_xIndex,
    input  logic [9:0]  i_yIndex,
    output logic [23:0] o_pixel,
    output logic [9:0]  o_xOut,
    output logic [9:0]  o_yOut,
    output logic        o_lastPixel,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_overflow
);

    localparam int LB_DEPTH = IN_WIDTH / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam int FIFO_AW  = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = FIFO_AW + 1;
    localparam int ENTRY_W  = 45;

    localparam logic [10:0]      COL_LIMIT = 11'(IN_WIDTH);
    localparam logic [10:0]      ROW_LIMIT = 11'(IN_HEIGHT);
    localparam logic [8:0]       LAST_X    = 9'(IN_WIDTH / 2 - 1);
    localparam logic [8:0]       LAST_Y    = 9'(IN_HEIGHT / 2 - 1);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

    // input decode
    logic [9:0]       col;
    logic [9:0]       row;
    logic [8:0]       pair_idx;
    logic [8:0]       row_pair;
    logic [LB_AW-1:0] lb_addr;
    logic             in_range;
    logic             take;
    logic [23:0]      exp_pix;

    // horizontal pairing
    logic [23:0]      hold_pix;
    logic             hold_ok;
    logic [8:0]       hold_pair;
    logic [9:0]       hold_row;
    logic             pair_ok;
    logic [8:0]       hsum_r, hsum_g, hsum_b;

    // line buffer: {even-row pair tag, hsum}
    logic [35:0]         lb_mem [LB_DEPTH];
    logic [35:0]         lb_rd;
    logic                lb_rd_ok;
    logic [LB_DEPTH-1:0] lb_valid;
    logic                lb_write;
    logic                lb_read;

    // vertical sum and result stage
    logic [9:0]         vsum_r, vsum_g, vsum_b;
    logic [23:0]        avg_pix;
    logic               emit;
    logic               res_valid;
    logic [ENTRY_W-1:0] res_entry;

    // output FIFO
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] fifo_wr_ptr;
    logic [FIFO_AW-1:0] fifo_rd_ptr;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_drop;
    logic [ENTRY_W-1:0] fifo_head;

    // Decode the incoming pixel, expand it to RGB888 and form the per-channel sums.
    // A pair only completes when its odd pixel follows the even pixel of the same
    // pair and row, so truncated or out-of-order pairs never combine.
    always_comb begin
        col      = i_xIndex - 10'd1;
        row      = i_yIndex;
        pair_idx = col[9:1];
        row_pair = row[9:1];
        lb_addr  = LB_AW'(pair_idx);
        in_range = ({1'b0, col} < COL_LIMIT) && ({1'b0, row} < ROW_LIMIT);
        take     = i_pixelValid && !i_frameStart && in_range;
        exp_pix  = {i_pixel[15:11], i_pixel[15:13],
                    i_pixel[10:5],  i_pixel[10:9],
                    i_pixel[4:0],   i_pixel[4:2]};
        pair_ok  = hold_ok && (hold_pair == pair_idx) && (hold_row == row);
        hsum_r   = {1'b0, hold_pix[23:16]} + {1'b0, exp_pix[23:16]};
        hsum_g   = {1'b0, hold_pix[15:8]}  + {1'b0, exp_pix[15:8]};
        hsum_b   = {1'b0, hold_pix[7:0]}   + {1'b0, exp_pix[7:0]};
        vsum_r   = {1'b0, hsum_r} + {1'b0, lb_rd[26:18]};
        vsum_g   = {1'b0, hsum_g} + {1'b0, lb_rd[17:9]};
        vsum_b   = {1'b0, hsum_b} + {1'b0, lb_rd[8:0]};
        avg_pix  = {8'((vsum_r + 10'd2) >> 2),
                    8'((vsum_g + 10'd2) >> 2),
                    8'((vsum_b + 10'd2) >> 2)};
        lb_write = take && !row[0] && col[0] && pair_ok;
        lb_read  = take && row[0] && !col[0];
        emit     = take && row[0] && col[0] && pair_ok && lb_rd_ok
                   && (lb_rd[35:27] == row_pair);
    end

    // Track whether an even-column pixel is waiting for its odd partner.
    always_ff @(posedge i_pclk) begin
        if (!i_reset) begin
            hold_ok <= 1'b0;
        end else if (i_frameStart) begin
            hold_ok <= 1'b0;
        end else if (take) begin
            hold_ok <= !col[0];
        end
    end

    // Capture the even-column pixel and where it came from.
    always_ff @(posedge i_pclk) begin
        if (take && !col[0]) begin
            hold_pix  <= exp_pix;
            hold_pair <= pair_idx;
            hold_row  <= row;
        end
    end

    // Line-buffer storage: even rows write pair sums, odd rows read one cycle ahead.
    always_ff @(posedge i_pclk) begin
        if (lb_write) begin
            lb_mem[lb_addr] <= {row_pair, hsum_r, hsum_g, hsum_b};
        end
        if (lb_read) begin
            lb_rd <= lb_mem[lb_addr];
        end
    end

    // Per-entry valid bits keep stale line-buffer data from a previous frame out.
    always_ff @(posedge i_pclk) begin
        if (!i_reset) begin
            lb_valid <= '0;
            lb_rd_ok <= 1'b0;
        end else if (i_frameStart) begin
            lb_valid <= '0;
            lb_rd_ok <= 1'b0;
        end else begin
            if (lb_write) begin
                lb_valid[lb_addr] <= 1'b1;
            end
            if (lb_read) begin
                lb_rd_ok <= lb_valid[lb_addr];
            end
        end
    end

    // Result register between the averaging math and the FIFO write.
    always_ff @(posedge i_pclk) begin
        if (!i_reset) begin
            res_valid <= 1'b0;
        end else begin
            res_valid <= emit;
        end
    end

    // Result payload: {pixel, x, y, last}.
    always_ff @(posedge i_pclk) begin
        if (emit) begin
            res_entry <= {avg_pix, 1'b0, pair_idx, 1'b0, row_pair,
                          (pair_idx == LAST_X) && (row_pair == LAST_Y)};
        end
    end

    // FIFO handshake decode; a full FIFO still accepts a push when it pops.
    always_comb begin
        o_valid   = (fifo_count != '0);
        fifo_full = (fifo_count == FIFO_FULL);
        fifo_pop  = o_valid && i_ready;
        fifo_push = res_valid && (!fifo_full || fifo_pop);
        fifo_drop = res_valid && fifo_full && !fifo_pop;
        fifo_head = fifo_mem[fifo_rd_ptr];
        {o_pixel, o_xOut, o_yOut, o_lastPixel} = o_valid ? fifo_head : '0;
    end

    // FIFO storage.
    always_ff @(posedge i_pclk) begin
        if (fifo_push) begin
            fifo_mem[fifo_wr_ptr] <= res_entry;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge i_pclk) begin
        if (!i_reset) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_count  <= '0;
        end else begin
            if (fifo_push) begin
                fifo_wr_ptr <= fifo_wr_ptr + FIFO_AW'(1);
            end
            if (fifo_pop) begin
                fifo_rd_ptr <= fifo_rd_ptr + FIFO_AW'(1);
            end
            if (fifo_push && !fifo_pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (!fifo_push && fifo_pop) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
        end
    end

    // Sticky overflow flag, cleared at the start of each frame.
    always_ff @(posedge i_pclk) begin
        if (!i_reset) begin
            o_overflow <= 1'b0;
        end else if (i_frameStart) begin
            o_overflow <= 1'b0;
        end else if (fifo_drop) begin
            o_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_downscale_2x.sv
// tb_pixel_downscale_2x
// Directed bench for the 2x downscaler on an 8x4 frame with a 4-entry FIFO.
module tb_pixel_downscale_2x;

    localparam int W = 8;
    localparam int H = 4;
    localparam int D = 4;

    logic        i_pclk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_frameStart = 1'b0;
    logic [15:0] i_pixel = '0;
    logic        i_pixelValid = 1'b0;
    logic [9:0]  i_xIndex = '0;
    logic [9:0]  i_yIndex = '0;
    logic        i_ready = 1'b1;
    logic [23:0] o_pixel;
    logic [9:0]  o_xOut;
    logic [9:0]  o_yOut;
    logic        o_lastPixel;
    logic        o_valid;
    logic        o_overflow;

    int checks = 0;
    int failures = 0;

    logic [44:0] outQ[$];

    // R8 expansion of R5 = 1..8, hand-computed as {R5, R5[4:2]}
    logic [7:0] rampExp [8] = '{8'h08, 8'h10, 8'h18, 8'h21, 8'h29, 8'h31, 8'h39, 8'h42};

    pixel_downscale_2x #(
        .IN_WIDTH  (W),
        .IN_HEIGHT (H),
        .FIFO_DEPTH(D)
    ) dut (
        .i_pclk      (i_pclk),
        .i_reset     (i_reset),
        .i_frameStart(i_frameStart),
        .i_pixel     (i_pixel),
        .i_pixelValid(i_pixelValid),
        .i_xIndex    (i_xIndex),
        .i_yIndex    (i_yIndex),
        .o_pixel     (o_pixel),
        .o_xOut      (o_xOut),
        .o_yOut      (o_yOut),
        .o_lastPixel (o_lastPixel),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_overflow  (o_overflow)
    );

    always #5 i_pclk = ~i_pclk;

    // Record every accepted FIFO head on the falling edge.
    always @(negedge i_pclk) begin
        if (o_valid && i_ready) begin
            outQ.push_back({o_pixel, o_xOut, o_yOut, o_lastPixel});
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] mkEntry(input logic [23:0] pix, input int x, input int y, input logic last);
        return {19'd0, pix, 10'(x), 10'(y), last};
    endfunction

    function automatic logic [63:0] headEntry();
        return {19'd0, o_pixel, o_xOut, o_yOut, o_lastPixel};
    endfunction

    function automatic logic [63:0] queueEntry(input int i);
        if (i < outQ.size()) return {19'd0, outQ[i]};
        return '1;
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(posedge i_pclk);
        #1;
    endtask

    task automatic pulseFrameStart();
        @(posedge i_pclk); #1;
        i_frameStart = 1'b1;
        @(posedge i_pclk); #1;
        i_frameStart = 1'b0;
    endtask

    // One pixel, valid for one cycle followed by one idle cycle.
    task automatic applyStimulus(input int col, input int row, input logic [15:0] pix);
        @(posedge i_pclk); #1;
        i_xIndex     = 10'(col + 1);
        i_yIndex     = 10'(row);
        i_pixel      = pix;
        i_pixelValid = 1'b1;
        @(posedge i_pclk); #1;
        i_pixelValid = 1'b0;
    endtask

    // Every pixel of block k carries R5 offset rStep*k on top of pixBase.
    task automatic sendRegion(input logic [15:0] pixBase, input int rStep,
                              input int r0, input int r1, input int c0, input int c1);
        logic [4:0] rOff;
        for (int r = r0; r <= r1; r++) begin
            for (int c = c0; c <= c1; c++) begin
                rOff = 5'(rStep * ((r / 2) * 4 + c / 2));
                applyStimulus(c, r, pixBase + {rOff, 11'd0});
            end
        end
    endtask

    task automatic checkFrameOutputs(input string tag, input logic [23:0] pix, input bit useRamp);
        logic [23:0] expPix;
        checkOutput({tag, "_count"}, 64'(outQ.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            expPix = useRamp ? {rampExp[k], 16'h0000} : pix;
            checkOutput($sformatf("%s_out%0d", tag, k), queueEntry(k), mkEntry(expPix, k % 4, k / 4, k == 7));
        end
    endtask

    initial begin
        $display("[TB] reset");
        waitCycles(3);
        checkOutput("rst_valid", 64'(o_valid), 64'd0);
        checkOutput("rst_pixel", 64'(o_pixel), 64'd0);
        checkOutput("rst_x", 64'(o_xOut), 64'd0);
        checkOutput("rst_y", 64'(o_yOut), 64'd0);
        checkOutput("rst_last", 64'(o_lastPixel), 64'd0);
        checkOutput("rst_ovf", 64'(o_overflow), 64'd0);
        i_reset = 1'b1;

        $display("[TB] test 1: white frame");
        pulseFrameStart();
        outQ.delete();
        sendRegion(16'hFFFF, 0, 0, 3, 0, 7);
        waitCycles(6);
        checkFrameOutputs("t1", 24'hFFFFFF, 1'b0);

        $display("[TB] test 2: rounding and latency");
        pulseFrameStart();
        outQ.delete();
        applyStimulus(0, 0, 16'h0000);
        applyStimulus(1, 0, 16'h0800);
        applyStimulus(0, 1, 16'h1000);
        applyStimulus(1, 1, 16'h1800);
        checkOutput("t2_valid_e0", 64'(o_valid), 64'd0);
        waitCycles(1);
        checkOutput("t2_valid_e1", 64'(o_valid), 64'd1);
        checkOutput("t2_head", headEntry(), mkEntry(24'h0C0000, 0, 0, 1'b0));
        waitCycles(3);
        checkOutput("t2_count", 64'(outQ.size()), 64'd1);

        $display("[TB] test 3: backpressure and overflow");
        i_ready = 1'b0;
        pulseFrameStart();
        outQ.delete();
        sendRegion(16'h0800, 1, 0, 1, 0, 7);
        waitCycles(3);
        checkOutput("t3_valid", 64'(o_valid), 64'd1);
        checkOutput("t3_head_a", headEntry(), mkEntry({rampExp[0], 16'h0}, 0, 0, 1'b0));
        checkOutput("t3_ovf_4", 64'(o_overflow), 64'd0);
        sendRegion(16'h0800, 1, 2, 2, 0, 7);
        sendRegion(16'h0800, 1, 3, 3, 0, 1);
        waitCycles(3);
        checkOutput("t3_ovf_5", 64'(o_overflow), 64'd1);
        checkOutput("t3_head_b", headEntry(), mkEntry({rampExp[0], 16'h0}, 0, 0, 1'b0));
        sendRegion(16'h0800, 1, 3, 3, 2, 7);
        waitCycles(3);
        checkOutput("t3_head_c", headEntry(), mkEntry({rampExp[0], 16'h0}, 0, 0, 1'b0));
        checkOutput("t3_none_taken", 64'(outQ.size()), 64'd0);
        i_ready = 1'b1;
        waitCycles(8);
        checkOutput("t3_drain_count", 64'(outQ.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("t3_drain%0d", k), queueEntry(k), mkEntry({rampExp[k], 16'h0}, k, 0, 1'b0));
        end
        checkOutput("t3_ovf_sticky", 64'(o_overflow), 64'd1);
        pulseFrameStart();
        checkOutput("t3_ovf_cleared", 64'(o_overflow), 64'd0);

        $display("[TB] test 4: missing even column");
        outQ.delete();
        sendRegion(16'h2000, 1, 0, 0, 0, 7);
        applyStimulus(1, 1, 16'h2000);
        sendRegion(16'h2000, 1, 1, 1, 2, 7);
        waitCycles(6);
        checkOutput("t4_count", 64'(outQ.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t4_out%0d", i), queueEntry(i), mkEntry({rampExp[i + 4], 16'h0}, i + 1, 0, 1'b0));
        end

        $display("[TB] test 5: out-of-range pixels");
        pulseFrameStart();
        outQ.delete();
        sendRegion(16'h5000, 0, 0, 0, 0, 7);
        applyStimulus(8, 0, 16'hFFFF);
        applyStimulus(9, 0, 16'hFFFF);
        applyStimulus(0, 4, 16'hFFFF);
        applyStimulus(1, 4, 16'hFFFF);
        applyStimulus(0, 5, 16'hFFFF);
        applyStimulus(1, 5, 16'hFFFF);
        applyStimulus(8, 1, 16'hFFFF);
        applyStimulus(9, 1, 16'hFFFF);
        sendRegion(16'h5000, 0, 1, 1, 0, 7);
        waitCycles(6);
        checkOutput("t5_count", 64'(outQ.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t5_out%0d", i), queueEntry(i), mkEntry(24'h520000, i, 0, 1'b0));
        end
        pulseFrameStart();
        outQ.delete();
        sendRegion(16'h0841, 0, 0, 3, 0, 7);
        waitCycles(6);
        checkFrameOutputs("t5_next", 24'h080808, 1'b0);

        $display("[TB] test 6: reset mid-pair");
        i_ready = 1'b0;
        pulseFrameStart();
        outQ.delete();
        sendRegion(16'hF800, 0, 0, 0, 0, 7);
        applyStimulus(0, 1, 16'hF800);
        applyStimulus(1, 1, 16'hF800);
        waitCycles(2);
        checkOutput("t6_valid_before", 64'(o_valid), 64'd1);
        applyStimulus(2, 1, 16'hF800);
        i_reset = 1'b0;
        waitCycles(1);
        i_reset = 1'b1;
        checkOutput("t6_valid_after_rst", 64'(o_valid), 64'd0);
        applyStimulus(3, 1, 16'hF800);
        i_ready = 1'b1;
        waitCycles(6);
        checkOutput("t6_no_output", 64'(outQ.size()), 64'd0);
        pulseFrameStart();
        outQ.delete();
        sendRegion(16'h0800, 1, 0, 3, 0, 7);
        waitCycles(6);
        checkFrameOutputs("t6_next", 24'h000000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
